// File: rtl/count_pkg.sv
// Shared definitions for the count_watch monitor: event codes and
// classifier state encoding.
package count_pkg;

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_WRAP = 2'b01;
  localparam logic [1:0] EV_JUMP = 2'b10;
  localparam logic [1:0] EV_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HELD = 2'd2
  } state_t;

endpackage

// File: rtl/count_watch_if.sv
// Bundle of the watched count input and the event/status outputs.
// master: the monitor; slave: the counter source plus event consumer.
interface count_watch_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] a_in;
  logic             ev_valid;
  logic             ev_ready;
  logic [1:0]       ev_code;
  logic [WIDTH-1:0] ev_value;
  logic [7:0]       wrap_cnt;
  logic             overflow;
  logic [LW-1:0]    fifo_level;

  modport master (
    input  a_in, ev_ready,
    output ev_valid, ev_code, ev_value, wrap_cnt, overflow, fifo_level
  );

  modport slave (
    output a_in, ev_ready,
    input  ev_valid, ev_code, ev_value, wrap_cnt, overflow, fifo_level
  );
endinterface

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO. The head is presented combinationally and
// reads as zero while empty. A push into a full FIFO is accepted only when
// a pop frees the slot on the same edge.
module event_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // Storage needs no reset; it is masked by empty on the read side.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/count_watch.sv
// Monitor for a free-running counter: classifies each sampled transition,
// queues non-increment events, and keeps a wrap tally and overflow flag.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_INIT | first edge after reset: capture prev, no event
// ST_RUN  | comparing samples; a repeat value emits HOLD
// ST_HELD | value repeating; further repeats are silent
module count_watch
  import count_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  count_watch_if.master bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t           state, state_d;
  logic [WIDTH-1:0] prev;
  logic             ev_det;
  logic [1:0]       code_d;
  logic             is_wrap;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_now;
  logic [WIDTH+1:0] head;
  logic [LW-1:0]    level;

  // Classify the current sample against prev and pick the next state.
  always_comb begin
    state_d = state;
    ev_det  = 1'b0;
    code_d  = EV_NONE;
    is_wrap = 1'b0;
    case (state)
      ST_INIT: state_d = ST_RUN;
      ST_RUN, ST_HELD: begin
        if (prev != '1 && bus.a_in == WIDTH'(prev + 1'b1)) begin
          state_d = ST_RUN;
        end else if (prev == '1 && bus.a_in == '0) begin
          ev_det  = 1'b1;
          code_d  = EV_WRAP;
          is_wrap = 1'b1;
          state_d = ST_RUN;
        end else if (bus.a_in == prev) begin
          if (state == ST_RUN) begin
            ev_det = 1'b1;
            code_d = EV_HOLD;
          end
          state_d = ST_HELD;
        end else begin
          ev_det  = 1'b1;
          code_d  = EV_JUMP;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign pop_now = bus.ev_ready && !fifo_empty;

  // State, sample history, wrap tally and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_INIT;
      prev         <= '0;
      bus.wrap_cnt <= '0;
      bus.overflow <= 1'b0;
    end else begin
      state <= state_d;
      prev  <= bus.a_in;
      if (is_wrap && bus.wrap_cnt != 8'hFF) bus.wrap_cnt <= bus.wrap_cnt + 1'b1;
      if (ev_det && fifo_full && !pop_now) bus.overflow <= 1'b1;
    end
  end

  event_fifo #(.W(WIDTH + 2), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ev_det),
    .din   ({code_d, bus.a_in}),
    .pop   (bus.ev_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign bus.ev_valid   = !fifo_empty;
  assign bus.ev_code    = head[WIDTH+1:WIDTH];
  assign bus.ev_value   = head[WIDTH-1:0];
  assign bus.fifo_level = level;

endmodule
